ldpc_layer_scheduler: RTL and testbench
=======================================

// Module: ldpc_layer_scheduler
// PURPOSE
//  Sequences the QC-LDPC proto-matrix ROM for a layered decoder: walks layers x columns,
//  skips zero-block entries, and streams (layer, col, shift) block commands to the datapath
//  over valid/ready. Handles per-layer flush, iteration count and syndrome early-stop.
//  Sits between the decoder top-level control and the ROM/decoder datapath.
// PARAMETERS
//  Z          54                    lifting size (27/54/81)
//  WIDTH      $clog2(Z)             shift width; all-ones = SKIP code
//  NUM_LAYERS 4                     proto rows (rate 5/6)
//  NUM_COLS   24                    proto columns
//  ADDRW      $clog2(NUM_LAYERS*NUM_COLS)  ROM address width
//  MAX_ITER   8                     iteration limit (>=1)
//  ITERW      $clog2(MAX_ITER+1)    iteration counter width
// PORTS
//  clk         in   1       single clock, all logic rising-edge
//  rst_n       in   1       synchronous, active-low reset
//  start       in   1       pulse: begin decode (ignored unless idle)
//  abort       in   1       synchronous abort -> idle, no done
//  busy        out  1       high from start accept until done/abort
//  done        out  1       1-cycle pulse at decode end
//  converged   out  1       valid with done, held until next start: syndrome passed
//  iter_count  out  ITERW   iterations completed; held until next start
//  rom_addr    out  ADDRW   = layer*NUM_COLS + col, ROM is async-read
//  rom_data    in   WIDTH   ROM entry at rom_addr, same cycle
//  out_valid   out  1       block command valid
//  out_ready   in   1       datapath accepts command
//  out_layer   out  $clog2(NUM_LAYERS)  layer index
//  out_col     out  $clog2(NUM_COLS)    column index
//  out_shift   out  WIDTH   circulant shift 0..Z-1
//  out_first   out  1       first non-skip block of its layer
//  layer_done  in   1       pulse: datapath finished all commands of current layer
//  syn_valid   in   1       pulse: syndrome result ready
//  syn_ok      in   1       syndrome all-zero, sampled with syn_valid
// BEHAVIOUR
//  Reset: state IDLE, counters 0, all outputs 0 (rom_addr 0).
//  States: IDLE -> SCAN -> LWAIT -> (SCAN | IWAIT) -> (SCAN | DONE) -> IDLE.
//  IDLE: start=1 -> clear iter_count/converged, layer=col=0, busy=1, SCAN next cycle.
//  SCAN: one ROM entry examined per cycle when 1-deep output reg is empty or out_ready=1.
//   - rom_data==SKIP: advance col, load nothing (reg may drain same cycle).
//   - else: load reg {layer,col,rom_data,first}, out_valid=1, advance col.
//   - out_ready=0 with reg full: hold col and reg stable (no field change while valid).
//   - after col NUM_COLS-1 advanced: go LWAIT; col wraps to 0.
//  Latency: start@T -> SCAN@T+1 (addr 0) -> out_valid@T+2 if entry 0 non-skip.
//  Throughput: 1 command/cycle with out_ready=1, skips cost 1 cycle each.
//  LWAIT: wait out reg drained AND layer_done; layer with zero emitted blocks skips
//   the layer_done wait. layer_done arriving early (before drain) is latched, not lost.
//   Then layer<NUM_LAYERS-1 -> layer++, SCAN; else IWAIT.
//  IWAIT: on syn_valid: iter_count++; syn_ok=1 -> converged=1, DONE;
//   else iter_count==MAX_ITER -> converged=0, DONE; else layer=0, SCAN.
//  DONE: done=1 one cycle, busy=0, -> IDLE.
//  abort (any state): next cycle IDLE, out_valid=0, busy=0, no done; iter_count held.
//  start while busy ignored; start and abort together in IDLE: abort wins.
//  rst_n low mid-decode: all state/outputs to reset values next edge.
// STRUCTURE
//  ldpc_pkg: NUM_LAYERS, NUM_COLS, sched_state_e enum, skip_code(WIDTH) function.
//  Single module; ROM (ProtoMatrix ROM) instantiated by parent and wired to rom_addr/rom_data.
//  No sub-module; output register and layer/col/iter counters inline.
// TESTING (stub ROM, Z=54, SKIP=6'h3F)
//  1 Row0 = {13,SKIP,7,SKIP..} others SKIP, out_ready=1, syn_ok=1 -> cmds (0,0,13,first),
//    (0,2,7); out_valid@T+2; layers1-3 no layer_done wait; done, converged=1, iter_count=1.
//  2 out_ready=0 for 5 cycles on first cmd -> fields stable, rom_addr stays 1, no drop/dup.
//  3 syn_ok=0 always, MAX_ITER=8 -> 8 full passes, done, converged=0, iter_count=8.
//  4 layer_done pulsed before last cmd accepted -> latched; layer 1 starts after drain.
//  5 abort mid-layer 2 -> IDLE next cycle, out_valid=0, no done; next start restarts at addr 0.
//  6 rst_n=0 mid-SCAN, start while busy -> all outputs 0; busy start ignored (no restart).

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared constants, scheduler state encoding and SKIP-code helper for the LDPC layer scheduler.
// Contents: NUM_LAYERS/NUM_COLS proto-matrix geometry, derived index widths, sched_state_e, skip_code().
// No logic; imported by ldpc_layer_scheduler.
package ldpc_pkg;

  localparam int NUM_LAYERS = 4;
  localparam int NUM_COLS   = 24;
  localparam int LAYERW     = $clog2(NUM_LAYERS);
  localparam int COLW       = $clog2(NUM_COLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_LWAIT,
    S_IWAIT,
    S_DONE
  } sched_state_e;

  // The all-ones shift value marks a zero block in the proto matrix.
  function automatic logic [31:0] skip_code(input int width);
    return (32'h1 << width) - 32'h1;
  endfunction

endpackage

// File: rtl/ldpc_layer_scheduler.sv
// Walks the QC-LDPC proto matrix layer by layer and streams non-zero (layer, col, shift) blocks.
// Latency: start -> ROM addr 0 next cycle -> first command the cycle after; 1 entry/cycle.
// Backpressure: 1-deep output register; out_ready=0 with a held command freezes the column walk.
// Ports: clk/rst_n (sync, active-low); start/abort/busy/done/converged/iter_count to control;
//        rom_addr/rom_data to an async-read ROM; out_* valid/ready command stream;
//        layer_done/syn_valid/syn_ok status from the datapath.
module ldpc_layer_scheduler
  import ldpc_pkg::*;
#(
  parameter int Z        = 54,
  parameter int WIDTH    = $clog2(Z),
  parameter int ADDRW    = $clog2(NUM_LAYERS * NUM_COLS),
  parameter int MAX_ITER = 8,
  parameter int ITERW    = $clog2(MAX_ITER + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [ITERW-1:0]  iter_count,
  output logic [ADDRW-1:0]  rom_addr,
  input  logic [WIDTH-1:0]  rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LAYERW-1:0] out_layer,
  output logic [COLW-1:0]   out_col,
  output logic [WIDTH-1:0]  out_shift,
  output logic              out_first,
  input  logic              layer_done,
  input  logic              syn_valid,
  input  logic              syn_ok
);

  localparam logic [WIDTH-1:0]  SKIP       = WIDTH'(skip_code(WIDTH));
  localparam logic [LAYERW-1:0] LAST_LAYER = LAYERW'(NUM_LAYERS - 1);
  localparam logic [COLW-1:0]   LAST_COL   = COLW'(NUM_COLS - 1);
  localparam logic [ITERW-1:0]  ITER_LIM   = ITERW'(MAX_ITER);

  sched_state_e      state;
  logic [LAYERW-1:0] layer;
  logic [COLW-1:0]   col;
  logic              emitted;     // at least one block of the current layer was loaded
  logic              ldone_seen;  // layer_done arrived before the layer could close

  logic can_load;
  logic is_skip;

  // The output register can take a new entry when empty or draining this cycle.
  assign can_load = !out_valid || out_ready;
  assign is_skip  = (rom_data == SKIP);
  assign rom_addr = ADDRW'(int'(layer) * NUM_COLS + int'(col));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      layer      <= '0;
      col        <= '0;
      emitted    <= 1'b0;
      ldone_seen <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      converged  <= 1'b0;
      iter_count <= '0;
      out_valid  <= 1'b0;
      out_layer  <= '0;
      out_col    <= '0;
      out_shift  <= '0;
      out_first  <= 1'b0;
    end else if (abort) begin
      // Abort drops any pending command and keeps the iteration count for inspection.
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_valid  <= 1'b0;
      emitted    <= 1'b0;
      ldone_seen <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            iter_count <= '0;
            converged  <= 1'b0;
            layer      <= '0;
            col        <= '0;
            emitted    <= 1'b0;
            ldone_seen <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b1;
            state      <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (layer_done) ldone_seen <= 1'b1;
          if (can_load) begin
            if (!is_skip) begin
              out_valid <= 1'b1;
              out_layer <= layer;
              out_col   <= col;
              out_shift <= rom_data;
              out_first <= !emitted;
              emitted   <= 1'b1;
            end else begin
              out_valid <= 1'b0;
            end
            if (col == LAST_COL) begin
              col   <= '0;
              state <= S_LWAIT;
            end else begin
              col <= col + 1'b1;
            end
          end
        end

        S_LWAIT: begin
          if (out_valid && out_ready) out_valid <= 1'b0;
          if (layer_done) ldone_seen <= 1'b1;
          // An empty layer has nothing for the datapath to finish, so it closes at once.
          if (!out_valid && (ldone_seen || layer_done || !emitted)) begin
            ldone_seen <= 1'b0;
            emitted    <= 1'b0;
            if (layer == LAST_LAYER) begin
              state <= S_IWAIT;
            end else begin
              layer <= layer + 1'b1;
              state <= S_SCAN;
            end
          end
        end

        S_IWAIT: begin
          if (syn_valid) begin
            iter_count <= iter_count + 1'b1;
            if (syn_ok) begin
              converged <= 1'b1;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= S_DONE;
            end else if (iter_count + 1'b1 == ITER_LIM) begin
              converged <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= S_DONE;
            end else begin
              layer <= '0;
              state <= S_SCAN;
            end
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_layer_scheduler.sv
// Directed bench for ldpc_layer_scheduler with a stub proto-matrix ROM (Z=54, SKIP=6'h3F).
// A negedge monitor logs accepted commands, done pulses and stall stability, and plays the
// datapath by pulsing layer_done after the last block of selected layers.
module tb_ldpc_layer_scheduler;
  import ldpc_pkg::*;

  localparam int NL = NUM_LAYERS;
  localparam int NC = NUM_COLS;
  localparam logic [5:0] SKIP = 6'h3F;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done, converged;
  logic [3:0] iter_count;
  logic [6:0] rom_addr;
  logic [5:0] rom_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_layer;
  logic [4:0] out_col;
  logic [5:0] out_shift;
  logic       out_first;
  logic       layer_done;
  logic       syn_valid = 1'b0;
  logic       syn_ok = 1'b0;

  logic [5:0] rom [128];
  logic       ldone_man = 1'b0;
  logic       ldone_auto = 1'b0;
  logic       ldone_arm = 1'b0;
  logic [3:0] ldone_mask = 4'h0;
  int         last_col [NL];

  assign rom_data   = rom[rom_addr];
  assign layer_done = ldone_auto | ldone_man;

  always #5 clk = ~clk;

  ldpc_layer_scheduler #(.Z(54), .MAX_ITER(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .converged(converged), .iter_count(iter_count),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_layer(out_layer), .out_col(out_col), .out_shift(out_shift), .out_first(out_first),
    .layer_done(layer_done), .syn_valid(syn_valid), .syn_ok(syn_ok)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [13:0] mk(input int l, input int c, input int s, input bit f);
    return {2'(l), 5'(c), 6'(s), f};
  endfunction

  logic [13:0] cur_cmd;
  assign cur_cmd = {out_layer, out_col, out_shift, out_first};

  // Monitor: command log, done capture, stall stability, auto layer_done.
  logic [13:0] cmds [$];
  int          done_cnt = 0;
  logic        conv_at_done = 1'b0;
  logic [3:0]  iter_at_done = '0;
  int          stab_err = 0;
  logic        prev_stall = 1'b0;
  logic [13:0] prev_cmd = '0;

  always @(negedge clk) begin
    ldone_auto = ldone_arm;
    ldone_arm  = 1'b0;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        cmds.push_back(cur_cmd);
        if (ldone_mask[out_layer] && int'(out_col) == last_col[out_layer]) ldone_arm = 1'b1;
      end
      if (prev_stall && out_valid && cur_cmd != prev_cmd) stab_err++;
      if (done) begin
        done_cnt++;
        conv_at_done = converged;
        iter_at_done = iter_count;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_cmd   = cur_cmd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = SKIP;
  endtask

  task automatic calc_last();
    for (int l = 0; l < NL; l++) begin
      last_col[l] = -1;
      for (int c = 0; c < NC; c++) if (rom[l*NC + c] != SKIP) last_col[l] = c;
    end
  endtask

  task automatic run_to_done(input string tag, input int budget);
    int n0;
    int k;
    n0 = done_cnt;
    k  = 0;
    while (done_cnt == n0 && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != n0), 1);
    tick();
    tick();
  endtask

  task automatic wait_cmd(input string tag, input int l, input int c, input int budget);
    int k;
    k = 0;
    while (!(out_valid && int'(out_layer) == l && int'(out_col) == c) && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(out_valid && int'(out_layer) == l && int'(out_col) == c), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    clear_rom();
    calc_last();
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_iter", iter_count, 0);
    check("rst_conv", converged, 0);
    rst_n = 1'b1;
    tick();

    // 1: row0 = {13, SKIP, 7, SKIP...}, converges on first syndrome.
    clear_rom();
    rom[0] = 6'd13;
    rom[2] = 6'd7;
    calc_last();
    ldone_mask = 4'b0001;
    out_ready = 1'b1;
    syn_valid = 1'b1;
    syn_ok    = 1'b1;
    cmds.delete();
    pulse_start();
    check("t1_busy", busy, 1);
    check("t1_addr_first", rom_addr, 0);
    check("t1_valid_early", out_valid, 0);
    tick();
    check("t1_valid_lat", out_valid, 1);
    check("t1_cmd0", cur_cmd, mk(0, 0, 13, 1));
    check("t1_addr_next", rom_addr, 1);
    run_to_done("t1", 400);
    check("t1_conv", conv_at_done, 1);
    check("t1_iter", iter_at_done, 1);
    check("t1_ncmds", cmds.size(), 2);
    check("t1_cmd1", cmds[1], mk(0, 2, 7, 0));
    check("t1_busy_end", busy, 0);

    // 2: stall the first command for 5 cycles.
    cmds.delete();
    stab_err = 0;
    pulse_start();
    out_ready = 1'b0;
    tick();
    repeat (5) tick();
    check("t2_valid_hold", out_valid, 1);
    check("t2_addr_hold", rom_addr, 1);
    check("t2_cmd_hold", cur_cmd, mk(0, 0, 13, 1));
    out_ready = 1'b1;
    run_to_done("t2", 400);
    check("t2_stable", stab_err, 0);
    check("t2_ncmds", cmds.size(), 2);
    check("t2_cmd0", cmds[0], mk(0, 0, 13, 1));
    check("t2_cmd1", cmds[1], mk(0, 2, 7, 0));

    // 3: never converges -> MAX_ITER passes.
    cmds.delete();
    syn_ok = 1'b0;
    pulse_start();
    run_to_done("t3", 3000);
    check("t3_conv", conv_at_done, 0);
    check("t3_iter", iter_at_done, 8);
    check("t3_ncmds", cmds.size(), 16);
    check("t3_cmd14", cmds[14], mk(0, 0, 13, 1));
    check("t3_cmd15", cmds[15], mk(0, 2, 7, 0));
    check("t3_iter_held", iter_count, 8);

    // 4: layer_done arrives while the last layer-0 command is still stalled.
    clear_rom();
    rom[0]  = 6'd5;
    rom[23] = 6'd9;
    rom[24] = 6'd11;
    calc_last();
    ldone_mask = 4'b0010;
    syn_ok = 1'b1;
    cmds.delete();
    pulse_start();
    wait_cmd("t4_last_valid", 0, 23, 60);
    out_ready = 1'b0;
    check("t4_addr_lwait", rom_addr, 0);
    ldone_man = 1'b1;
    tick();
    ldone_man = 1'b0;
    repeat (3) tick();
    check("t4_addr_held", rom_addr, 0);
    check("t4_cmd_held", cur_cmd, mk(0, 23, 9, 0));
    check("t4_ncmds_stall", cmds.size(), 1);
    out_ready = 1'b1;
    tick();
    check("t4_drained", out_valid, 0);
    tick();
    check("t4_layer1_addr", rom_addr, 24);
    run_to_done("t4", 400);
    check("t4_ncmds", cmds.size(), 3);
    check("t4_cmd2", cmds[2], mk(1, 0, 11, 1));
    check("t4_conv", conv_at_done, 1);

    // 5: abort during layer 2, then a clean restart.
    clear_rom();
    for (int l = 0; l < NL; l++) begin
      rom[l*NC + 0] = 6'(l*10 + 1);
      rom[l*NC + 5] = 6'(l*10 + 6);
    end
    calc_last();
    ldone_mask = 4'hF;
    cmds.delete();
    pulse_start();
    n0 = done_cnt;
    wait_cmd("t5_l2_valid", 2, 0, 400);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_valid", out_valid, 0);
    repeat (4) tick();
    check("t5_no_done", done_cnt, n0);
    check("t5_iter_held", iter_count, 0);
    check("t5_still_idle", busy, 0);
    cmds.delete();
    pulse_start();
    check("t5_restart_addr", rom_addr, 0);
    tick();
    check("t5_restart_cmd", cur_cmd, mk(0, 0, 1, 1));
    run_to_done("t5", 600);
    check("t5_ncmds", cmds.size(), 8);
    check("t5_cmd7", cmds[7], mk(3, 5, 36, 0));
    check("t5_conv", conv_at_done, 1);

    // start and abort together in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort_wins", busy, 0);

    // 6: start while busy is ignored; reset mid-scan clears everything.
    cmds.delete();
    pulse_start();
    tick();
    tick();
    check("t6_addr2", rom_addr, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_start_ignored", rom_addr, 3);
    repeat (3) tick();
    check("t6_valid_pre_rst", out_valid, 1);
    check("t6_cmd_pre_rst", cur_cmd, mk(0, 5, 6, 0));
    rst_n = 1'b0;
    tick();
    check("t6_rst_busy", busy, 0);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_addr", rom_addr, 0);
    check("t6_rst_cmd", cur_cmd, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_iter", iter_count, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("t6_idle_after_rst", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
